// File: rtl/lock_key_ctrl_pkg.sv
// lock_pkg: shared definitions for the key-delivery controller.
//   key_state_t  - controller state enum (IDLE, LOAD, CHECK, RUN, ERR)
//   KEY_PAR_EVEN - XOR of key bits plus parity bit that marks a valid key
//   clog2        - ceil(log2(n)), minimum 1, used to size the counters
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } key_state_t;

    localparam logic KEY_PAR_EVEN = 1'b0;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/lock_key_ctrl.sv
// lock_key_ctrl: receives a serial activation key (MSB first, then one
// even-parity bit), validates it and presents it in parallel to a locked
// FSM, holding that FSM in reset until a valid key is applied.
// Ports:
//   clk           - clock, all registers update on the rising edge
//   rst           - asynchronous active-high reset
//   key_start     - single-cycle request to (re)load a key
//   key_bit_valid - qualifies key_bit_in, one beat per clock
//   key_bit_in    - serial key bit
//   key_bits      - parallel key to the locked FSM (0 unless running)
//   fsm_rst       - locked-FSM reset, low only while a valid key is applied
//   key_ready     - high while a validated key is applied
//   key_err       - high after a parity failure or load timeout
//   busy          - high while loading or checking
module lock_key_ctrl
    import lock_pkg::*;
#(
    parameter int KEY_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_bit_valid,
    input  logic             key_bit_in,
    output logic [KEY_W-1:0] key_bits,
    output logic             fsm_rst,
    output logic             key_ready,
    output logic             key_err,
    output logic             busy
);

    localparam int CNT_W = clog2(KEY_W + 2);
    localparam int TO_W  = clog2(TIMEOUT);
    // Count value held when the parity beat arrives.
    localparam logic [CNT_W-1:0] CNT_PAR = CNT_W'(KEY_W);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W:0]   sr_q, sr_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [KEY_W-1:0] key_bits_q, key_bits_d;
    logic             fsm_rst_q, key_ready_q, key_err_q, busy_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        to_d       = to_q;
        key_bits_d = key_bits_q;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (key_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    sr_d    = '0;
                    to_d    = '0;
                end
            end
            ST_LOAD: begin
                // A restart discards any beat presented in the same cycle;
                // a beat takes priority over an expiring timeout.
                if (key_start) begin
                    cnt_d = '0;
                    sr_d  = '0;
                    to_d  = '0;
                end else if (key_bit_valid) begin
                    sr_d  = {sr_q[KEY_W-1:0], key_bit_in};
                    cnt_d = cnt_q + CNT_W'(1);
                    to_d  = '0;
                    if (cnt_q == CNT_PAR) state_d = ST_CHECK;
                end else if (to_q == TO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_CHECK: begin
                if ((^sr_q) == KEY_PAR_EVEN) begin
                    state_d    = ST_RUN;
                    key_bits_d = sr_q[KEY_W:1];
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The key is only ever driven while running, so leaving RUN clears
        // it on the same edge that fsm_rst rises.
        if (state_d != ST_RUN) key_bits_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            to_q        <= '0;
            key_bits_q  <= '0;
            fsm_rst_q   <= 1'b1;
            key_ready_q <= 1'b0;
            key_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            to_q        <= to_d;
            key_bits_q  <= key_bits_d;
            fsm_rst_q   <= (state_d != ST_RUN);
            key_ready_q <= (state_d == ST_RUN);
            key_err_q   <= (state_d == ST_ERR);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
        end
    end

    assign key_bits  = key_bits_q;
    assign fsm_rst   = fsm_rst_q;
    assign key_ready = key_ready_q;
    assign key_err   = key_err_q;
    assign busy      = busy_q;

endmodule
